// File: rtl/ahblite_keypad_scan.sv
// AHB-Lite keypad scanner: row-strobed matrix scan, frame-level debounce, press/release event FIFO.
// Latency: zero-wait-state bus; an event is pushed DB_FRAMES full frames after a stable change.
// Backpressure: none on the bus (HREADYOUT=1); a full FIFO drops new events and sets sticky overflow.
module ahblite_keypad_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DB_FRAMES  = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [31:0]     HADDR,
  input  logic [3:0]      HPROT,
  input  logic [2:0]      HSIZE,
  input  logic [1:0]      HTRANS,
  input  logic [31:0]     HWDATA,
  input  logic            HWRITE,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic [31:0]     HRDATA,
  output logic            HRESP,
  output logic [ROWS-1:0] row_out,
  input  logic [COLS-1:0] col_in,
  output logic            key_irq
);

  localparam int NKEYS = ROWS * COLS;
  localparam int KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, COMPARE, EMIT} state_t;

  // bus data-phase registers
  logic [1:0]       addr_q;
  logic             rd_q, wr_q;
  logic [1:0]       ctrl_q;

  // scan / debounce state
  state_t           state_q;
  logic [RW-1:0]    row_q;
  logic [DW-1:0]    div_q;
  logic [NKEYS-1:0] raw_q, prev_q, deb_q, chg_q;
  logic [3:0]       stable_q, stable_d;
  logic [KW-1:0]    k_q;
  logic [ROWS-1:0]  row_out_q;
  logic [COLS-1:0]  col_s1_q, col_s2_q;

  // event FIFO: entry = {press, index[7:0]}
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             irq_q;

  logic       en, wr_ctrl, wr_stat, flush, ovf_clr;
  logic       fifo_empty, fifo_full, pop, push_vld, push_ok;
  logic [8:0] push_dat;

  assign en         = ctrl_q[0];
  assign wr_ctrl    = wr_q && (addr_q == 2'd2);
  assign wr_stat    = wr_q && (addr_q == 2'd1);
  assign flush      = wr_ctrl && HWDATA[2];
  assign ovf_clr    = wr_stat && HWDATA[18];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop        = rd_q && (addr_q == 2'd0) && !fifo_empty;
  // an EMIT cut short by disable must not leak a push in its last cycle
  assign push_vld   = en && (state_q == EMIT) && chg_q[k_q];
  assign push_dat   = {deb_q[k_q], 8'(k_q)};
  // a same-cycle pop frees the slot, so a full FIFO still accepts
  assign push_ok    = push_vld && (!fifo_full || pop);

  assign stable_d = (raw_q != prev_q) ? 4'd1 :
                    (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign row_out   = row_out_q;
  assign key_irq   = irq_q;

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HPROT, HSIZE, HTRANS[0],
                       HWDATA[31:19], HWDATA[17:3]};

  // capture address phase; flags are single-cycle so a data phase never repeats a pop
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= 2'd0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      ctrl_q <= 2'd0;
    end else begin
      addr_q <= HADDR[3:2];
      rd_q   <= HSEL && HTRANS[1] && HREADY && !HWRITE;
      wr_q   <= HSEL && HTRANS[1] && HREADY && HWRITE;
      if (wr_ctrl) ctrl_q <= HWDATA[1:0];
    end
  end

  // read mux, driven from the registered address during the data phase
  always_comb begin
    HRDATA = 32'd0;
    if (rd_q) begin
      case (addr_q)
        2'd0: if (!fifo_empty) HRDATA = {1'b1, 22'd0, mem_q[rptr_q]};
        2'd1: HRDATA = {13'd0, ovf_q, fifo_full, fifo_empty, 7'd0, 9'(cnt_q)};
        2'd2: HRDATA = {30'd0, ctrl_q};
        default: HRDATA = 32'(deb_q);
      endcase
    end
  end

  // two-flop synchroniser for the asynchronous column inputs (idle = pulled up)
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= col_in;
      col_s2_q <= col_s1_q;
    end
  end

  // scan FSM: drive rows, capture raw frame, debounce, walk changed keys
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      row_q     <= '0;
      div_q     <= '0;
      raw_q     <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      chg_q     <= '0;
      stable_q  <= '0;
      k_q       <= '0;
      row_out_q <= '1;
    end else if (!en) begin
      // partial frame and stability history are meaningless after a gap
      state_q   <= IDLE;
      row_q     <= '0;
      div_q     <= '0;
      raw_q     <= '0;
      stable_q  <= '0;
      k_q       <= '0;
      row_out_q <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= DRIVE;
          row_q     <= '0;
          div_q     <= '0;
          row_out_q <= ~ROWS'(1);
        end
        DRIVE: begin
          if (div_q == DW'(SCAN_DIV - 1)) begin
            raw_q[int'(row_q) * COLS +: COLS] <= ~col_s2_q;
            div_q <= '0;
            if (row_q == RW'(ROWS - 1)) begin
              state_q   <= COMPARE;
              row_out_q <= '1;
            end else begin
              row_q     <= row_q + RW'(1);
              row_out_q <= ~(ROWS'(1) << (int'(row_q) + 1));
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        COMPARE: begin
          stable_q <= stable_d;
          prev_q   <= raw_q;
          if ((stable_d == 4'(DB_FRAMES)) && (raw_q != deb_q)) begin
            chg_q   <= raw_q ^ deb_q;
            deb_q   <= raw_q;
            k_q     <= '0;
            state_q <= EMIT;
          end else begin
            state_q   <= DRIVE;
            row_q     <= '0;
            div_q     <= '0;
            row_out_q <= ~ROWS'(1);
          end
        end
        EMIT: begin
          if (k_q == KW'(NKEYS - 1)) begin
            state_q   <= DRIVE;
            row_q     <= '0;
            div_q     <= '0;
            row_out_q <= ~ROWS'(1);
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO storage; flush discards a same-cycle push
  always_ff @(posedge HCLK) begin
    if (push_ok && !flush) mem_q[wptr_q] <= push_dat;
  end

  // FIFO pointers, fill count and sticky overflow (a new overflow beats a same-cycle clear)
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop)     rptr_q <= rptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_vld && !push_ok) ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
    end
  end

  // level interrupt while events are pending
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq_q <= 1'b0;
    else          irq_q <= ctrl_q[1] && !fifo_empty;
  end

endmodule

// File: tb/tb_ahblite_keypad_scan.sv
// Bench for ahblite_keypad_scan: keypad matrix model drives col_in from row_out,
// a queue-based model predicts events, FIFO status, key state and interrupt.
// Directed scenarios followed by randomized key patterns.
module tb_ahblite_keypad_scan;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DB_FRAMES = 2, DEPTH = 4, NK = 16;

  logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [3:0]  HPROT = '0;
  logic [2:0]  HSIZE = 3'b010;
  logic [1:0]  HTRANS = '0;
  logic        HREADYOUT, HRESP, key_irq;
  logic [31:0] HRDATA;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_in;
  logic [NK-1:0]   keys = '0;

  int n_cmp = 0, n_err = 0;

  // reference model state
  int            q[$];
  logic          mdl_ovf = 1'b0;
  logic [NK-1:0] mdl_deb = '0;
  logic [1:0]    mdl_ctrl = 2'b00;

  ahblite_keypad_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                        .DB_FRAMES(DB_FRAMES), .FIFO_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .row_out(row_out), .col_in(col_in), .key_irq(key_irq));

  always #5 HCLK = ~HCLK;

  // physical matrix: a pressed key shorts its row to its column
  always_comb begin
    col_in = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!row_out[r] && keys[r*COLS+c]) col_in[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_push(input int ev);
    if (q.size() < DEPTH) q.push_back(ev);
    else mdl_ovf = 1'b1;
  endfunction

  function automatic void model_keys(input logic [NK-1:0] nk);
    for (int k = 0; k < NK; k++)
      if (nk[k] != mdl_deb[k]) model_push((int'(nk[k]) << 8) | k);
    mdl_deb = nk;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = q.size();
    if (q.size() == 0)     s |= 32'h0001_0000;
    if (q.size() == DEPTH) s |= 32'h0002_0000;
    if (mdl_ovf)           s |= 32'h0004_0000;
    return s;
  endfunction

  function automatic logic [31:0] exp_event();
    if (q.size() == 0) return 32'd0;
    return 32'h8000_0000 | q[0];
  endfunction

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic rd_event(input string tag);
    logic [31:0] d, e;
    e = exp_event();
    ahb_read(32'h0, d);
    chk(tag, d, e);
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic drain(input string tag);
    rd_chk({tag, "_status"}, 32'h4, exp_status());
    while (q.size() > 0) rd_event({tag, "_event"});
    rd_event({tag, "_empty_event"});
    rd_chk({tag, "_status_after"}, 32'h4, exp_status());
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    ahb_write(32'h8, d);
    mdl_ctrl = d[1:0];
    if (d[2]) begin q.delete(); mdl_ovf = 1'b0; end
  endtask

  task automatic wr_status(input logic [31:0] d);
    ahb_write(32'h4, d);
    if (d[18]) mdl_ovf = 1'b0;
  endtask

  task automatic settle(input logic [NK-1:0] nk);
    keys = nk;
    repeat (200) @(posedge HCLK);
    #1;
    model_keys(nk);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  prev_row;
    logic        found;

    // 1: reset state
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_row_out", row_out, 32'hF);
    chk("rst_irq", key_irq, 0);
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp", HRESP, 0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    rd_chk("rst_event", 32'h0, 32'h0);
    rd_chk("rst_status", 32'h4, 32'h0001_0000);
    rd_chk("rst_ctrl", 32'h8, 32'h0);
    rd_chk("rst_keystate", 32'hC, 32'h0);
    chk("rst_row_idle", row_out, 32'hF);

    // 2: single press of key 6 (row 1, col 2)
    wr_ctrl(32'h3);
    rd_chk("ctrl_rb", 32'h8, 32'h3);
    settle(16'h0040);
    chk("t2_irq_set", key_irq, 1);
    rd_chk("t2_keystate", 32'hC, 32'h0000_0040);
    rd_chk("t2_status", 32'h4, exp_status());
    ahb_read(32'h0, d);
    chk("t2_event_const", d, 32'h8000_0106);
    chk("t2_event_model", d, exp_event());
    void'(q.pop_front());
    chk("t2_irq_hold", key_irq, 1);
    @(posedge HCLK); #1;
    chk("t2_irq_fall", key_irq, 0);
    rd_chk("t2_status_empty", 32'h4, 32'h0001_0000);
    settle(16'h0000);
    drain("t2_release");

    // 3: one-frame glitch on key 6 is rejected
    keys = 16'h0040;
    repeat (10) @(posedge HCLK);
    settle(16'h0000);
    rd_chk("t3_status", 32'h4, 32'h0001_0000);
    rd_chk("t3_keystate", 32'hC, 32'h0);

    // 4: eight changes into four entries -> overflow
    settle(16'h8421);
    settle(16'h0000);
    rd_chk("t4_status", 32'h4, 32'h0006_0004);
    chk("t4_model_status", exp_status(), 32'h0006_0004);
    while (q.size() > 0) rd_event("t4_event");
    rd_chk("t4_status_drained", 32'h4, 32'h0005_0000);
    wr_status(32'h0004_0000);
    rd_chk("t4_ovf_clr", 32'h4, 32'h0001_0000);

    // 5: disable mid-frame keeps debounced state, no spurious release
    settle(16'h0008);
    drain("t5_press");
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge HCLK); #1;
      if (row_out == 4'b1011) found = 1'b1;
    end
    chk("t5_sync_row2", found, 1);
    wr_ctrl(32'h2);
    @(posedge HCLK); #1;
    chk("t5_row_release", row_out, 32'hF);
    repeat (5) @(posedge HCLK);
    #1;
    chk("t5_row_idle", row_out, 32'hF);
    rd_chk("t5_keystate_held", 32'hC, 32'h0000_0008);
    wr_ctrl(32'h3);
    settle(16'h0008);
    rd_chk("t5_no_spurious", 32'h4, 32'h0001_0000);
    rd_chk("t5_keystate", 32'hC, 32'h0000_0008);
    settle(16'h0000);
    drain("t5_release");

    // 6: pop coincides with an EMIT push while full
    settle(16'h0007);
    settle(16'h0005);
    rd_chk("t6_full", 32'h4, 32'h0002_0004);
    keys = 16'h8005;
    found = 1'b0;
    prev_row = row_out;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge HCLK); #1;
      if (prev_row == 4'b0111 && row_out == 4'hF) begin
        @(posedge HCLK); #1;
        if (row_out == 4'hF) found = 1'b1;
      end
      prev_row = row_out;
    end
    chk("t6_sync_emit", found, 1);
    if (found) begin
      // key 15 is pushed in the 16th EMIT cycle; the read data phase lands there
      repeat (14) @(posedge HCLK);
      #1;
      rd_event("t6_pop_event");
    end
    repeat (100) @(posedge HCLK);
    #1;
    model_keys(16'h8005);
    rd_chk("t6_status", 32'h4, 32'h0002_0004);
    chk("t6_model_status", exp_status(), 32'h0002_0004);
    while (q.size() > 1) rd_event("t6_event");
    rd_chk("t6_last_const", 32'h0, 32'h8000_010F);
    void'(q.pop_front());
    rd_chk("t6_empty", 32'h4, 32'h0001_0000);

    // randomized key patterns against the model
    for (int it = 0; it < 12; it++) begin
      logic [31:0] r;
      r = $urandom;
      settle(r[15:0] & r[31:16]);
      rd_chk("rnd_status", 32'h4, exp_status());
      chk("rnd_irq", key_irq, (mdl_ctrl[1] && q.size() > 0) ? 1 : 0);
      rd_chk("rnd_keystate", 32'hC, 32'(mdl_deb));
      case ($urandom_range(0, 2))
        0: drain("rnd_drain");
        1: begin
          wr_status(32'h0004_0000);
          rd_chk("rnd_ovf_clr", 32'h4, exp_status());
          if (q.size() > 0) rd_event("rnd_head");
        end
        default: begin
          wr_ctrl(32'h7);
          rd_chk("rnd_flush", 32'h4, 32'h0001_0000);
          rd_chk("rnd_ctrl", 32'h8, 32'h3);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
